// File: rtl/sync_pkg.sv
// sync_pkg: state codes and widths shared by the acquisition sequencer, the
// self-test pattern generator and the state display/readout path.
package sync_pkg;
  localparam int STATE_W     = 8;
  localparam int STATE_COUNT = 9;
  typedef enum logic [STATE_W-1:0] {
    IDLE              = 8'd0,
    FG_WAIT_OPTO      = 8'd1,
    FG_WAIT_OPEN      = 8'd2,
    WAIT_PHASE_FRONT  = 8'd3,
    WAIT_PHASE_DELAY  = 8'd4,
    TRIGGER_PROLONG   = 8'd5,
    DETECTOR_BUSY     = 8'd6,
    DETECTOR_WAIT     = 8'd7,
    DETECTOR_FINISHED = 8'd8
  } sync_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: W-bit two-flop synchronizer, async active-low reset.
// Ports: clock, reset_n, d (async inputs), q (synchronized outputs).
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/sync_fsm.sv
// sync_fsm: acquisition sequencer (arm, frame grabber, phase front + delay, trigger, detector handshake).
// Ports: clock, reset_n (async low); start, abort (sync); opto, fg_open, phase, det_busy (async);
//        trigger, done, timeout (registered pulses/levels); state_out (8-bit state code).
// Build option: define SYNC_FSM_TIMEOUT_EN to compile in the wait-state timeout.
module sync_fsm
  import sync_pkg::*;
#(
  parameter int CNT_W        = 24,
  parameter int PHASE_DELAY  = 1000,
  parameter int TRIGGER_LEN  = 500,
  parameter int WAIT_TIMEOUT = 1000000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               opto,
  input  logic               fg_open,
  input  logic               phase,
  input  logic               det_busy,
  output logic               trigger,
  output logic               done,
  output logic               timeout,
  output logic [STATE_W-1:0] state_out
);
`ifdef SYNC_FSM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] PD_LAST = CNT_W'(PHASE_DELAY - 1);
  localparam logic [CNT_W-1:0] TL_LAST = CNT_W'(TRIGGER_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(WAIT_TIMEOUT - 1);
  sync_state_t state, state_next, tgt;
  logic [CNT_W-1:0] cnt;
  logic opto_s, fg_open_s, phase_s, det_busy_s, phase_q;
  logic go, wait_st, to_hit, front;
  sync_2ff #(.W(4)) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      ({det_busy, phase, fg_open, opto}),
    .q      ({det_busy_s, phase_s, fg_open_s, opto_s})
  );
  // A front needs phase_s low on the previous cycle, so a level already high
  // on entry to WAIT_PHASE_FRONT is never taken as a front.
  assign front = phase_s & ~phase_q;
  always_comb begin
    go  = 1'b1;
    tgt = IDLE;
    unique case (state)
      IDLE:             begin go = start;          tgt = FG_WAIT_OPTO;      end
      FG_WAIT_OPTO:     begin go = opto_s;         tgt = FG_WAIT_OPEN;      end
      FG_WAIT_OPEN:     begin go = fg_open_s;      tgt = WAIT_PHASE_FRONT;  end
      WAIT_PHASE_FRONT: begin go = front;          tgt = WAIT_PHASE_DELAY;  end
      WAIT_PHASE_DELAY: begin go = cnt == PD_LAST; tgt = TRIGGER_PROLONG;   end
      TRIGGER_PROLONG:  begin go = cnt == TL_LAST; tgt = DETECTOR_BUSY;     end
      DETECTOR_BUSY:    begin go = det_busy_s;     tgt = DETECTOR_WAIT;     end
      DETECTOR_WAIT:    begin go = ~det_busy_s;    tgt = DETECTOR_FINISHED; end
      default:          begin go = 1'b1;           tgt = IDLE;              end
    endcase
    wait_st    = state inside {FG_WAIT_OPTO, FG_WAIT_OPEN, WAIT_PHASE_FRONT, DETECTOR_BUSY, DETECTOR_WAIT};
    // Exit condition beats timeout; abort suppresses the timeout pulse.
    to_hit     = TO_EN && wait_st && !go && !abort && cnt == TO_LAST;
    state_next = (abort || to_hit) ? IDLE : go ? tgt : state;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      phase_q <= 1'b0;
      trigger <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= (state_next != state) ? '0 : cnt + {{(CNT_W-1){1'b0}}, ~&cnt};
      phase_q <= phase_s;
      trigger <= state_next == TRIGGER_PROLONG;
      done    <= state_next == DETECTOR_FINISHED;
      timeout <= to_hit;
    end
  assign state_out = state;
endmodule

// File: doc/sync_fsm.md
# sync_fsm

Acquisition sequencer of the synchronization block. It arms on a start pulse and waits for the frame grabber (opto, then gate open). It then waits for a phase reference front and delays by a programmed count. It fires a stretched trigger and tracks the detector busy/idle handshake. It drives the 8-bit state code consumed by the state display/readout path, using the same encoding as the self-test pattern generator, so either source can feed that path.

## Interface
- CNT_W, 24: width of the shared delay/timeout counter.
- PHASE_DELAY, 1000: cycles from detected phase front to trigger rise; legal range 1..2^CNT_W-1.
- TRIGGER_LEN, 500: trigger high time in cycles; legal range 1..2^CNT_W-1.
- WAIT_TIMEOUT, 1000000: maximum cycles spent in any wait state; legal range 1..2^CNT_W-1.

- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  synchronous arm request, sampled only in IDLE.
- abort  in  1  synchronous; forces IDLE from any state.
- opto  in  1  frame-grabber opto signal; asynchronous.
- fg_open  in  1  frame-grabber gate-open; asynchronous.
- phase  in  1  phase reference; asynchronous.
- det_busy  in  1  detector busy; asynchronous.
- trigger  out  1  detector trigger, registered.
- done  out  1  one-cycle pulse on sequence completion.
- timeout  out  1  one-cycle pulse on wait-state timeout.
- state_out  out  8  current state code.

## Operation
- Asynchronous inputs pass through 2-flop synchronizers (opto_s, fg_open_s, phase_s, det_busy_s). The phase front is phase_s high with its previous value low.
- State codes: IDLE=0, FG_WAIT_OPTO=1, FG_WAIT_OPEN=2, WAIT_PHASE_FRONT=3, WAIT_PHASE_DELAY=4, TRIGGER_PROLONG=5, DETECTOR_BUSY=6, DETECTOR_WAIT=7, DETECTOR_FINISHED=8. Other codes are never produced.
- Transitions:
  - IDLE → FG_WAIT_OPTO on start.
  - FG_WAIT_OPTO → FG_WAIT_OPEN on opto_s.
  - FG_WAIT_OPEN → WAIT_PHASE_FRONT on fg_open_s.
  - WAIT_PHASE_FRONT → WAIT_PHASE_DELAY on phase front.
  - WAIT_PHASE_DELAY → TRIGGER_PROLONG after PHASE_DELAY cycles.
  - TRIGGER_PROLONG → DETECTOR_BUSY after TRIGGER_LEN cycles.
  - DETECTOR_BUSY → DETECTOR_WAIT on det_busy_s high.
  - DETECTOR_WAIT → DETECTOR_FINISHED on det_busy_s low.
  - DETECTOR_FINISHED → IDLE unconditionally after 1 cycle.
- Counter: one counter, cleared on every state change, incrementing otherwise, saturating at all-ones. It is shared by the delay states and the timeout.
- Wait states are 1, 2, 3, 6 and 7. If the counter reaches WAIT_TIMEOUT−1 without the exit condition, the FSM goes to IDLE and timeout pulses. If the exit condition and the timeout coincide, the exit condition wins.
- Priority: reset > abort > timeout > normal transition. An abort produces neither done nor timeout. start while not in IDLE is ignored.
- A phase front already in progress when WAIT_PHASE_FRONT is entered is not accepted; a fresh low→high edge is required.

## Timing
- Reset values: state_out=0 (IDLE), trigger=0, done=0, timeout=0, counter=0, synchronizer flops=0.
- Input latency: a pin change is visible to the FSM 2 clocks after first capture. The phase front adds 1 cycle for edge detection.
- Phase front detected in cycle E: WAIT_PHASE_DELAY from E+1, TRIGGER_PROLONG from E+1+PHASE_DELAY.
- trigger is a flop updated alongside the state register. It is high exactly in the TRIGGER_PROLONG cycles, TRIGGER_LEN cycles long, and is glitch-free.
- done is high exactly in the DETECTOR_FINISHED cycle.
- timeout is high in the first IDLE cycle after a timeout exit.
- state_out changes on the same edge as the state register, with no extra latency.
- Asserting reset_n low mid-sequence drops trigger immediately (asynchronously).

## Configuration
- SYNC_FSM_TIMEOUT_EN defined: wait-state timeout compiled in as described.
- Not defined: wait states wait indefinitely, timeout is tied 0, and the counter is used only in states 4 and 5 (it still saturates).

## Structure
- Package sync_pkg holds:
  - typedef enum logic [7:0] sync_state_t with the codes above, shared with the self-test generator and the readout path;
  - localparams for state count and code width.
- Sub-module sync_2ff: parameterized-width 2-flop synchronizer with asynchronous active-low reset, instanced once with width 4.

## Test plan
- Full sequence, PHASE_DELAY=10, TRIGGER_LEN=5: start, opto, fg_open, phase rise, det_busy 1 then 0 → state_out 1..8 in order, then 0. trigger high exactly 5 cycles, rising 11 cycles after the edge-detect cycle; done a single pulse.
- Phase held high before entering state 3 → FSM stays in 3 until phase falls and rises again.
- SYNC_FSM_TIMEOUT_EN, WAIT_TIMEOUT=100, opto never asserted → after 100 cycles in state 1, state_out=0 with a 1-cycle timeout pulse and no done.
- abort asserted during TRIGGER_PROLONG → next cycle state_out=0 and trigger=0; no done and no timeout.
- reset_n pulled low in DETECTOR_WAIT → state_out=0 and trigger=0 asynchronously. After release, start is required before state 1 is entered.
- start pulsed in state 6 → ignored; sequence completes normally.
